// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared period counter and per-channel double-buffered
// thresholds, programmed through the extended ctrl-code path (device in RAL[7:4], data on GAH).
module pwm_multi #(
  parameter int unsigned PWMBITS  = 8,
  parameter int unsigned NCHAN    = 4,
  parameter int unsigned PRESCALE = 1,
  parameter logic [3:0]  DDEV     = 4'hd,
  parameter logic [3:0]  CDEV     = 4'hc
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             nCTRL,
  input  logic [7:0]       RAL,
  input  logic [7:0]       GAH,
  output logic [NCHAN-1:0] PWM,
  output logic             SYNC,
  output logic [5:0]       CSEL
);

  localparam logic [7:0] PRE_LAST  = 8'(PRESCALE - 1);
  localparam logic [6:0] NCHAN_W   = 7'(NCHAN);
  localparam logic [5:0] CSEL_LAST = 6'(NCHAN - 1);

  logic [PWMBITS-1:0] cnt;
  logic [7:0]         pre;
  logic               cfg_mode;
  logic               cfg_autoinc;
  logic [PWMBITS-1:0] staged [NCHAN];
  logic [PWMBITS-1:0] active [NCHAN];

  logic               tick;
  logic               wrap;
  logic               is_cfg;
  logic               is_dat;
  logic               is_srst;
  logic               csel_ok;
  logic [5:0]         csel_next;
  logic [PWMBITS-1:0] cnt_rev;
  logic [PWMBITS-1:0] cmp;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    tick      = (pre == PRE_LAST);
    wrap      = tick && (cnt == '1);
    is_cfg    = !nCTRL && (RAL[3:0] == 4'h0) && (RAL[7:4] == CDEV);
    is_dat    = !nCTRL && (RAL[3:0] == 4'h0) && (RAL[7:4] == DDEV);
    is_srst   = !nCTRL && (RAL[3:0] >= 4'h4) && (RAL[1:0] == 2'b11);
    csel_ok   = ({1'b0, CSEL} < NCHAN_W);
    csel_next = (!csel_ok || CSEL == CSEL_LAST) ? 6'd0 : CSEL + 6'd1;
  end

  // Bit-reversed compare spreads the high time across the period, which filters easier for audio.
  always_comb begin
    cnt_rev = '0;
    for (int i = 0; i < int'(PWMBITS); i++) cnt_rev[i] = cnt[PWMBITS-1-i];
    cmp = cfg_mode ? cnt_rev : cnt;
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      cnt         <= '0;
      pre         <= '0;
      cfg_mode    <= 1'b0;
      cfg_autoinc <= 1'b0;
      CSEL        <= '0;
      PWM         <= '0;
      SYNC        <= 1'b0;
      // NOTE: staged/active are per-channel flops rather than a RAM, so they can be cleared here.
      for (int k = 0; k < int'(NCHAN); k++) begin
        staged[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      SYNC <= wrap;
      if (tick) begin
        pre <= '0;
        cnt <= cnt + PWMBITS'(1);
      end else begin
        pre <= pre + 8'd1;
      end

      for (int k = 0; k < int'(NCHAN); k++) PWM[k] <= (cmp < active[k]);

      if (is_srst) begin
        cfg_mode    <= 1'b0;
        cfg_autoinc <= 1'b0;
        CSEL        <= '0;
        for (int k = 0; k < int'(NCHAN); k++) begin
          staged[k] <= '0;
          active[k] <= '0;
        end
      end else begin
        // NOTE: non-blocking assignment makes active[k] take staged[k] from before a same-edge write.
        if (wrap) begin
          for (int k = 0; k < int'(NCHAN); k++) active[k] <= staged[k];
        end
        if (is_cfg) begin
          cfg_mode    <= GAH[7];
          cfg_autoinc <= GAH[6];
          CSEL        <= GAH[5:0];
        end
        if (is_dat) begin
          // An out-of-range CSEL matches no channel, so the data is dropped but autoinc still runs.
          for (int k = 0; k < int'(NCHAN); k++) begin
            if (CSEL == 6'(k)) staged[k] <= GAH[7 -: PWMBITS];
          end
          if (cfg_autoinc) CSEL <= csel_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: measures per-period high counts and SYNC timing on a PRESCALE=1
// and a PRESCALE=3 instance, comparing against expectations queued when stimulus is driven.
module tb_pwm_multi;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       nCTRL;
  logic [7:0] RAL;
  logic [7:0] GAH;

  logic [3:0] pwm_a, pwm_b;
  logic       sync_a, sync_b;
  logic [5:0] csel_a, csel_b;

  pwm_multi #(.PWMBITS(8), .NCHAN(4), .PRESCALE(1)) dut_a (
    .CLK(CLK), .nRESET(nRESET), .nCTRL(nCTRL), .RAL(RAL), .GAH(GAH),
    .PWM(pwm_a), .SYNC(sync_a), .CSEL(csel_a)
  );

  pwm_multi #(.PWMBITS(8), .NCHAN(4), .PRESCALE(3)) dut_b (
    .CLK(CLK), .nRESET(nRESET), .nCTRL(nCTRL), .RAL(RAL), .GAH(GAH),
    .PWM(pwm_b), .SYNC(sync_b), .CSEL(csel_b)
  );

  always #5 CLK = ~CLK;

  localparam logic [7:0] CFG = 8'hc0;
  localparam logic [7:0] DAT = 8'hd0;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_tog;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic push4(input string pfx, input int e0, input int e1, input int e2, input int e3);
    push({pfx, "_ch0"}, e0);
    push({pfx, "_ch1"}, e1);
    push({pfx, "_ch2"}, e2);
    push({pfx, "_ch3"}, e3);
  endtask

  task automatic pop_check(input int got);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.exp);
    end
  endtask

  // Drive one ctrl event; the posedge after this call's start captures it.
  task automatic ctrl_write(input logic [7:0] ral, input logic [7:0] gah);
    nCTRL = 1'b0;
    RAL   = ral;
    GAH   = gah;
    @(negedge CLK);
    nCTRL = 1'b1;
    RAL   = 8'h00;
    GAH   = 8'h00;
  endtask

  task automatic wait_sync_a(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if (sync_a) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 1);
  endtask

  task automatic wait_sync_b(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge CLK);
      if (sync_b) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 1);
  endtask

  // Called on a SYNC cycle; the next 256 samples each reflect one cnt value under the new thresholds.
  task automatic measure_a();
    int   hi[4];
    int   tog = 0;
    logic prev = pwm_a[0];
    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm_a[c]);
      if (pwm_a[0] !== prev) tog++;
      prev = pwm_a[0];
    end
    for (int c = 0; c < 4; c++) pop_check(hi[c]);
    last_tog = tog;
  endtask

  task automatic measure_b();
    int   hi = 0;
    int   rises = 0;
    logic prev = pwm_b[0];
    for (int i = 0; i < 768; i++) begin
      @(negedge CLK);
      hi += int'(pwm_b[0]);
      if (pwm_b[0] && !prev) rises++;
      prev = pwm_b[0];
    end
    pop_check(hi);
    pop_check(rises);
    pop_check(int'(sync_b));
  endtask

  initial begin
    int n;
    nRESET = 1'b0;
    nCTRL  = 1'b0;
    RAL    = 8'hd0;
    GAH    = 8'hff;
    repeat (3) @(negedge CLK);
    check("rst_pwm", 32'(pwm_a), 0);
    check("rst_sync", 32'(sync_a), 0);
    check("rst_csel", 32'(csel_a), 0);

    nRESET = 1'b1;
    nCTRL  = 1'b1;
    RAL    = 8'h00;
    GAH    = 8'h00;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      n++;
      if (sync_a) break;
    end
    check("first_sync_delay", n, 256);
    @(negedge CLK);
    check("sync_width", 32'(sync_a), 0);

    // Linear, autoinc from channel 0, four back-to-back data writes.
    ctrl_write(CFG, 8'h40);
    ctrl_write(DAT, 8'h40);
    check("autoinc_csel1", 32'(csel_a), 1);
    ctrl_write(DAT, 8'h80);
    ctrl_write(DAT, 8'hff);
    ctrl_write(DAT, 8'h00);
    check("autoinc_wrap_csel", 32'(csel_a), 0);
    push4("lin", 64, 128, 255, 0);
    wait_sync_a("lin_sync");
    measure_a();

    // Bit-reversed compare, channel 0 threshold 0x80: toggles every cycle.
    ctrl_write(CFG, 8'h80);
    ctrl_write(DAT, 8'h80);
    push4("rev", 128, 128, 255, 0);
    wait_sync_a("rev_sync");
    measure_a();
    check("rev_toggles", last_tog, 256);

    // Double buffering: 0x20 staged early, 0x10 written on the exact wrap edge.
    ctrl_write(CFG, 8'h00);
    ctrl_write(DAT, 8'h20);
    repeat (253) @(negedge CLK);
    ctrl_write(DAT, 8'h10);
    check("db_wrap_coincide", 32'(sync_a), 1);
    push4("db_p1", 32, 128, 255, 0);
    push4("db_p2", 16, 128, 255, 0);
    measure_a();
    measure_a();

    // Out-of-range select: write dropped, autoinc returns CSEL to 0.
    ctrl_write(CFG, 8'h45);
    check("oor_csel_set", 32'(csel_a), 5);
    ctrl_write(DAT, 8'h77);
    check("oor_csel_wrap", 32'(csel_a), 0);
    push4("oor", 16, 128, 255, 0);
    wait_sync_a("oor_sync");
    measure_a();

    // Soft reset via normal-ctrl reset code clears thresholds, select and config.
    ctrl_write(CFG, 8'hc2);
    check("srst_csel_pre", 32'(csel_a), 2);
    ctrl_write(8'h0f, 8'h00);
    check("srst_csel", 32'(csel_a), 0);
    @(negedge CLK);
    check("srst_pwm_now", 32'(pwm_a), 0);
    push4("srst", 0, 0, 0, 0);
    wait_sync_a("srst_sync");
    measure_a();

    // Prescale 3: threshold 1 gives one 3-cycle pulse per 768-cycle period.
    wait_sync_b("pre_sync0");
    ctrl_write(CFG, 8'h00);
    ctrl_write(DAT, 8'h01);
    push("pre_highs", 3);
    push("pre_rises", 1);
    push("pre_period_sync", 1);
    wait_sync_b("pre_sync1");
    measure_b();

    check("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
